// File: rtl/nvme_buffer_reader_if.sv
// Handshake bundle for the NVMe buffer read engine: request channel, RAM read port,
// output beat stream and completion pulse. master = the reader, slave = its environment.
interface nvme_buffer_reader_if #(
  parameter int ADDR_BITS = 8,
  parameter int LEN_BITS  = 9
);
  logic                 req_valid;
  logic                 req_ready;
  logic [ADDR_BITS-1:0] req_addr;
  logic [LEN_BITS-1:0]  req_len;
  logic [3:0]           req_first_be;
  logic [3:0]           req_last_be;

  logic                 ram_re;
  logic [ADDR_BITS-1:0] ram_raddr;
  logic [127:0]         ram_dout;

  logic                 m_valid;
  logic                 m_ready;
  logic [127:0]         m_data;
  logic [3:0]           m_keep;
  logic                 m_last;

  logic                 done;

  modport master (
    input  req_valid, req_addr, req_len, req_first_be, req_last_be,
    input  ram_dout, m_ready,
    output req_ready, ram_re, ram_raddr,
    output m_valid, m_data, m_keep, m_last, done
  );

  modport slave (
    output req_valid, req_addr, req_len, req_first_be, req_last_be,
    output ram_dout, m_ready,
    input  req_ready, ram_re, ram_raddr,
    input  m_valid, m_data, m_keep, m_last, done
  );
endinterface

// File: rtl/nvme_buffer_reader.sv
// Read-side drain engine: issues buffer RAM reads for a line-range request and streams
// the lines out through a 2-entry FIFO that absorbs the RAM's one-cycle read latency.
//
// state    | meaning
// IDLE     | waiting for a request; req_ready high unless done is pulsing
// READ     | issuing RAM reads under the FIFO credit rule
// DRAIN    | all reads issued; waiting for the m_last handshake
module nvme_buffer_reader #(
  parameter int ADDR_BITS = 8,
  parameter int LEN_BITS  = 9
) (
  input logic                 clk,
  input logic                 rst_n,
  nvme_buffer_reader_if.master bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]           state_q, state_d;
  logic                 done_q, done_d;
  logic [ADDR_BITS-1:0] addr_q;
  logic [LEN_BITS-1:0]  len_q;
  logic [LEN_BITS-1:0]  idx_q;
  logic [3:0]           first_be_q;
  logic [3:0]           last_be_q;

  logic                 infl_q;
  logic [3:0]           infl_keep_q;
  logic                 infl_last_q;

  logic [127:0]         fifo_data_q [2];
  logic [3:0]           fifo_keep_q [2];
  logic                 fifo_last_q [2];
  logic                 wr_ptr_q;
  logic                 rd_ptr_q;
  logic [1:0]           count_q;

  logic                 accept;
  logic                 pop;
  logic [2:0]           credit;
  logic                 ram_re;
  logic                 is_last_rd;
  logic [3:0]           rd_keep;
  logic [127:0]         push_data;

  assign accept     = (state_q == ST_IDLE) && !done_q && bus.req_valid;
  assign pop        = (count_q != 2'd0) && bus.m_ready;
  // Slots already committed (stored + arriving) minus the one leaving this cycle.
  assign credit     = {1'b0, count_q} + {2'b00, infl_q} - {2'b00, pop};
  assign ram_re     = (state_q == ST_READ) && (credit < 3'd2);
  assign is_last_rd = (idx_q == len_q - LEN_BITS'(1));

  always_comb begin
    rd_keep = 4'hF;
    if (len_q == LEN_BITS'(1))
      rd_keep = first_be_q & last_be_q;
    else if (idx_q == '0)
      rd_keep = first_be_q;
    else if (is_last_rd)
      rd_keep = last_be_q;
  end

  always_comb begin
    push_data = '0;
    for (int i = 0; i < 4; i++)
      push_data[32*i +: 32] = infl_keep_q[i] ? bus.ram_dout[32*i +: 32] : 32'h0;
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.req_len == '0) done_d  = 1'b1;
          else                   state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (ram_re && is_last_rd) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && fifo_last_q[rd_ptr_q]) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      done_q         <= 1'b0;
      addr_q         <= '0;
      len_q          <= '0;
      idx_q          <= '0;
      first_be_q     <= '0;
      last_be_q      <= '0;
      infl_q         <= 1'b0;
      infl_keep_q    <= '0;
      infl_last_q    <= 1'b0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_keep_q[0] <= '0;
      fifo_keep_q[1] <= '0;
      fifo_last_q[0] <= 1'b0;
      fifo_last_q[1] <= 1'b0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;

      if (accept && bus.req_len != '0) begin
        addr_q     <= bus.req_addr;
        len_q      <= bus.req_len;
        idx_q      <= '0;
        first_be_q <= bus.req_first_be;
        last_be_q  <= bus.req_last_be;
      end else if (ram_re) begin
        addr_q <= addr_q + ADDR_BITS'(1);
        idx_q  <= idx_q + LEN_BITS'(1);
      end

      infl_q <= ram_re;
      if (ram_re) begin
        infl_keep_q <= rd_keep;
        infl_last_q <= is_last_rd;
      end

      if (infl_q) begin
        fifo_data_q[wr_ptr_q] <= push_data;
        fifo_keep_q[wr_ptr_q] <= infl_keep_q;
        fifo_last_q[wr_ptr_q] <= infl_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;

      count_q <= count_q + {1'b0, infl_q} - {1'b0, pop};
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE) && !done_q;
  assign bus.ram_re    = ram_re;
  assign bus.ram_raddr = addr_q;
  assign bus.m_valid   = (count_q != 2'd0);
  assign bus.m_data    = fifo_data_q[rd_ptr_q];
  assign bus.m_keep    = fifo_keep_q[rd_ptr_q];
  assign bus.m_last    = fifo_last_q[rd_ptr_q];
  assign bus.done      = done_q;

endmodule

// File: doc/nvme_buffer_reader.md
# nvme_buffer_reader

Read-side drain engine for the NVMe data buffer RAM. It accepts a transfer request (start line address, length in 128-bit lines, first/last dword enables) and issues RAM reads. It absorbs the RAM's one-cycle read latency and streams the lines out on a valid/ready interface with full backpressure. It sits between the 128-bit buffer RAM's read port and the host/DMA data path, as the counterpart of the dword-masked write side.

## Interface
Parameters:
- ADDR_BITS, 8, width of buffer line address; address space 2**ADDR_BITS lines
- LEN_BITS, 9, width of request length in lines; max length 2**LEN_BITS-1

Ports:
- clk  in  1  single clock for all logic, including the RAM read port
- rst_n  in  1  one clock; reset is asynchronous and active-low
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_addr  in  ADDR_BITS  first line address
- req_len  in  LEN_BITS  number of 128-bit lines; 0 is legal
- req_first_be  in  4  dword enables for first line
- req_last_be  in  4  dword enables for last line
- ram_re  out  1  RAM read enable
- ram_raddr  out  ADDR_BITS  RAM read address
- ram_dout  in  128  RAM read data, valid the cycle after ram_re
- m_valid  out  1  output beat valid
- m_ready  in  1  output beat consumed when m_valid && m_ready
- m_data  out  128  line data; dword lanes with m_keep bit 0 driven to 0
- m_keep  out  4  dword enables; bit i covers m_data[32i+31:32i]
- m_last  out  1  final beat of request
- done  out  1  one-cycle pulse at request completion

## Operation
- States: IDLE, READ, DRAIN.
  - IDLE: req_ready=1. On accept with req_len!=0: latch addr/len/BEs, go to READ. With req_len=0: go to IDLE, pulse done next cycle, no beats, no ram_re.
  - READ: issue reads while the credit rule allows. After the last read issues, go to DRAIN.
  - DRAIN: wait for the final beat handshake. Then pulse done, clear m_valid if the FIFO is empty, return to IDLE.
- Output buffer: 2-entry FIFO of {data, keep, last}, written the cycle after each ram_re.
- Credit rule: ram_re=1 only if (fifo_count + inflight - pop_this_cycle) < 2, where inflight is a ram_re issued the previous cycle.
  - The FIFO never overflows.
  - With m_ready held high, sustained throughput is 1 line/cycle.
- Address: ram_raddr increments by 1 per issued read and wraps modulo 2**ADDR_BITS (0xFF -> 0x00 at default).
- Keep generation:
  - len=1: keep = first_be & last_be.
  - Otherwise: first line first_be, last line last_be, middle lines 4'hF.
  - Masked lanes are zeroed in m_data.
- m_last=1 only on the beat carrying line len-1.
- req_ready is 0 outside IDLE. A new request is accepted no earlier than the cycle after done.
- m_data/m_keep/m_last are held stable while m_valid && !m_ready.

## Timing
- Reset values: req_ready=1, ram_re=0, ram_raddr=0, m_valid=0, m_data=0, m_keep=0, m_last=0, done=0. FIFO empty, state IDLE.
- Reset asserted mid-transfer: all outputs take their reset values immediately (asynchronously). In-flight read data is discarded and the partial transfer is abandoned with no done pulse.
- Accept at edge E0: ram_re=1 with ram_raddr=req_addr in the cycle after E0. m_valid rises after E2 (2-cycle request-to-data latency).
- With m_ready=1, a len-N request produces N consecutive beats. done pulses in the cycle after the m_last handshake, so the first cycle with done=1 is N+2 cycles after accept.
- done pulses exactly 1 cycle per accepted request, including len=0.
- No combinational path from m_ready to m_valid or m_data. ram_re may depend combinationally on m_ready (pop-aware credit).

## Test plan
- Single line: addr=0x10, len=1, first_be=4'b1110, last_be=4'b0111, RAM line 0x10 = 128'h44..33..22..11 -> one beat, keep=4'b0110, lanes 0 and 3 zero, m_last=1, done 1 cycle later.
- Streaming: addr=0x20, len=4, BEs=4'hF, m_ready=1 -> ram_raddr 0x20..0x23 on 4 consecutive cycles; 4 back-to-back beats starting 2 cycles after accept; m_last on beat 4.
- Backpressure: len=8, m_ready toggled with random pattern / held low 10 cycles -> data in order, no loss or duplication, at most 2 reads outstanding beyond beats consumed, outputs stable while stalled.
- Wrap: addr=0xFE, len=4 -> reads at 0xFE, 0xFF, 0x00, 0x01; data matches those lines.
- Zero length: len=0 -> no ram_re, no m_valid, done pulses 1 cycle after accept; req_ready back high.
- Reset mid-transfer: rst_n low after 3 of 8 beats -> outputs at reset values immediately, no done. A new len=2 request after reset completes normally.
